// File: rtl/turfio_cout_multi_pkg.sv
// -----------------------------------------------------------------------------
// turfio_pkg
// Shared definitions for the multi-channel TURFIO COUT serializer.
//   TRAIN_VALUE_DEFAULT : training word sent on a lane while its train select
//                         is high
//   laneSrc_e           : which source a lane loads at a frame boundary
//   frameLen()          : frame length in clocks (WORD_BITS/BITS_PER_CLK). It
//                         returns 0 when that length is not a power of two of
//                         at least 4, so the top level can refuse to elaborate.
// -----------------------------------------------------------------------------
package turfio_pkg;

  localparam logic [31:0] TRAIN_VALUE_DEFAULT = 32'hA55A6996;

  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_HELD  = 2'd1,
    SRC_TRAIN = 2'd2
  } laneSrc_e;

  // A frame length of 0 marks an unusable WORD_BITS/BITS_PER_CLK pair.
  function automatic int frameLen(input int wordBits, input int bitsPerClk);
    int len;
    if (bitsPerClk <= 0) return 0;
    if ((wordBits % bitsPerClk) != 0) return 0;
    len = wordBits / bitsPerClk;
    if (len < 4) return 0;
    if ((len & (len - 1)) != 0) return 0;
    return len;
  endfunction

endpackage

// File: rtl/turfio_cout_lane.sv
// -----------------------------------------------------------------------------
// turfio_cout_lane
// One COUT channel: a shift register that is either reloaded at the frame
// boundary or shifted right by BITS_PER_CLK, plus the registered, optionally
// inverted output lane.
//   if_clk_x2_i   : serial-side clock
//   if_rst_n_i    : asynchronous active-low reset
//   load_i        : reload the shift register at this edge
//   train_i       : load TRAIN_VALUE instead of command data
//   held_valid_i  : the shared holding register has a command
//   held_word_i   : this channel's word from the holding register
//   dout_o        : BITS_PER_CLK-bit lane, bit 0 first in time
// -----------------------------------------------------------------------------
module turfio_cout_lane
  import turfio_pkg::*;
#(
  parameter int                   WORD_BITS    = 32,
  parameter int                   BITS_PER_CLK = 2,
  parameter logic [WORD_BITS-1:0] TRAIN_VALUE  = WORD_BITS'(TRAIN_VALUE_DEFAULT),
  parameter logic                 INVERT       = 1'b0
) (
  input  logic                    if_clk_x2_i,
  input  logic                    if_rst_n_i,
  input  logic                    load_i,
  input  logic                    train_i,
  input  logic                    held_valid_i,
  input  logic [WORD_BITS-1:0]    held_word_i,
  output logic [BITS_PER_CLK-1:0] dout_o
);

  laneSrc_e                 laneSrc;
  logic [WORD_BITS-1:0]     shift_q;
  logic [WORD_BITS-1:0]     shift_d;
  logic [BITS_PER_CLK-1:0]  dout_q;

  // Pick the load source: training overrides held data, and an empty holding
  // register falls back to the all-zero idle word.
  always_comb begin
    laneSrc = SRC_IDLE;
    if (train_i) begin
      laneSrc = SRC_TRAIN;
    end else if (held_valid_i) begin
      laneSrc = SRC_HELD;
    end
  end

  // Shift right with zero fill, or reload at the frame boundary.
  always_comb begin
    shift_d = shift_q >> BITS_PER_CLK;
    if (load_i) begin
      case (laneSrc)
        SRC_TRAIN: shift_d = TRAIN_VALUE;
        SRC_HELD:  shift_d = held_word_i;
        default:   shift_d = '0;
      endcase
    end
  end

  // The output register takes the low slice of the next shift value, so the
  // first slice of a freshly loaded word is on dout_o in the cycle right after
  // the load. An all-zero shift register shows the inversion level.
  always_ff @(posedge if_clk_x2_i or negedge if_rst_n_i) begin
    if (!if_rst_n_i) begin
      shift_q <= '0;
      dout_q  <= {BITS_PER_CLK{INVERT}};
    end else begin
      shift_q <= shift_d;
      dout_q  <= shift_d[BITS_PER_CLK-1:0] ^ {BITS_PER_CLK{INVERT}};
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/turfio_cout_multi.sv
// -----------------------------------------------------------------------------
// turfio_cout_multi
// Multi-channel TURFIO COUT serializer. Splits NUM_CH command words into
// BITS_PER_CLK-bit lanes per clock, framed by the external phase strobe, for
// external ODDR/OBUFDS primitives.
//   if_clk_x2_i        : serial-side clock
//   if_rst_n_i         : asynchronous active-low reset
//   if_clk_x2_phase_i  : one-cycle strobe marking frame clock 0
//   cmd_i              : command words, channel c at [c*WORD_BITS +: WORD_BITS]
//   cmd_valid_i        : command valid
//   cmd_ready_o        : holding register empty
//   train_i            : per-channel train select
//   sync_ok_o          : phase counter has locked to the strobe
//   phase_err_o        : sticky misaligned-strobe flag
//   phase_err_clr_i    : clears phase_err_o
//   dout_o             : per-channel lanes, bit 0 first in time (ODDR D1)
//   frame_start_o      : dout_o carries the first slice of a new word
// -----------------------------------------------------------------------------
module turfio_cout_multi
  import turfio_pkg::*;
#(
  parameter int                   NUM_CH       = 4,
  parameter int                   WORD_BITS    = 32,
  parameter int                   BITS_PER_CLK = 2,
  parameter logic [WORD_BITS-1:0] TRAIN_VALUE  = WORD_BITS'(TRAIN_VALUE_DEFAULT),
  parameter logic [NUM_CH-1:0]    INV_MASK     = {NUM_CH{1'b0}}
) (
  input  logic                           if_clk_x2_i,
  input  logic                           if_rst_n_i,
  input  logic                           if_clk_x2_phase_i,
  input  logic [NUM_CH*WORD_BITS-1:0]    cmd_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [NUM_CH-1:0]              train_i,
  output logic                           sync_ok_o,
  output logic                           phase_err_o,
  input  logic                           phase_err_clr_i,
  output logic [NUM_CH*BITS_PER_CLK-1:0] dout_o,
  output logic                           frame_start_o
);

  localparam int L  = frameLen(WORD_BITS, BITS_PER_CLK);
  localparam int CW = $clog2((L >= 4) ? L : 4);

  // The strobe is seen one cycle late through phaseBuf_q, and the counter it
  // forces takes effect one more cycle later, hence the reload value of 2.
  localparam logic [CW-1:0] CNT_RESYNC  = CW'(2);
  localparam logic [CW-1:0] CNT_ALIGNED = CW'(1);
  localparam logic [CW-1:0] CNT_CAPTURE = CW'(L - 3);

  if (L == 0) begin : gen_bad_frame_len
    $error("turfio_cout_multi: WORD_BITS/BITS_PER_CLK must be a power of two of at least 4");
  end

  logic                        phaseBuf_q;
  logic [CW-1:0]               counter_q;
  logic [CW-1:0]               counter_d;
  logic                        syncOk_q;
  logic                        phaseErr_q;
  logic                        phaseErr_d;
  logic                        doCapture_q;
  logic                        holdFull_q;
  logic                        holdFull_d;
  logic [NUM_CH*WORD_BITS-1:0] heldCmd_q;
  logic                        frameStart_q;
  logic                        loadEn;
  logic                        accept;

  assign loadEn = doCapture_q & syncOk_q;
  assign accept = cmd_valid_i & ~holdFull_q;

  // Counter resyncs on every buffered strobe and free-runs modulo L otherwise.
  always_comb begin
    counter_d = counter_q + CW'(1);
    if (phaseBuf_q) begin
      counter_d = CNT_RESYNC;
    end
  end

  // A strobe that lands anywhere but the aligned slot after lock raises the
  // error; raising wins over a simultaneous clear.
  always_comb begin
    phaseErr_d = phaseErr_q;
    if (phaseBuf_q && syncOk_q && (counter_q != CNT_ALIGNED)) begin
      phaseErr_d = 1'b1;
    end else if (phase_err_clr_i) begin
      phaseErr_d = 1'b0;
    end
  end

  // A load always empties the holding register, whether or not any lane used
  // it. Accept only happens while empty, so the two never collide.
  always_comb begin
    holdFull_d = holdFull_q;
    if (loadEn && holdFull_q) begin
      holdFull_d = 1'b0;
    end else if (accept) begin
      holdFull_d = 1'b1;
    end
  end

  // Phase tracking, lock, error and capture-timing state.
  always_ff @(posedge if_clk_x2_i or negedge if_rst_n_i) begin
    if (!if_rst_n_i) begin
      phaseBuf_q   <= 1'b0;
      counter_q    <= '0;
      syncOk_q     <= 1'b0;
      phaseErr_q   <= 1'b0;
      doCapture_q  <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      phaseBuf_q   <= if_clk_x2_phase_i;
      counter_q    <= counter_d;
      syncOk_q     <= syncOk_q | phaseBuf_q;
      phaseErr_q   <= phaseErr_d;
      doCapture_q  <= (counter_q == CNT_CAPTURE);
      frameStart_q <= loadEn;
    end
  end

  // One-entry command holding register; cmd_i is only sampled at accept.
  always_ff @(posedge if_clk_x2_i or negedge if_rst_n_i) begin
    if (!if_rst_n_i) begin
      holdFull_q <= 1'b0;
      heldCmd_q  <= '0;
    end else begin
      holdFull_q <= holdFull_d;
      if (accept) begin
        heldCmd_q <= cmd_i;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : gen_lane
    turfio_cout_lane #(
      .WORD_BITS    (WORD_BITS),
      .BITS_PER_CLK (BITS_PER_CLK),
      .TRAIN_VALUE  (TRAIN_VALUE),
      .INVERT       (INV_MASK[c])
    ) u_lane (
      .if_clk_x2_i  (if_clk_x2_i),
      .if_rst_n_i   (if_rst_n_i),
      .load_i       (loadEn),
      .train_i      (train_i[c]),
      .held_valid_i (holdFull_q),
      .held_word_i  (heldCmd_q[c*WORD_BITS +: WORD_BITS]),
      .dout_o       (dout_o[c*BITS_PER_CLK +: BITS_PER_CLK])
    );
  end

  assign cmd_ready_o   = ~holdFull_q;
  assign sync_ok_o     = syncOk_q;
  assign phase_err_o   = phaseErr_q;
  assign frame_start_o = frameStart_q;

endmodule

// File: doc/turfio_cout_multi.md
Name: turfio_cout_multi

Overview:
Parametrised multi-channel successor to the single TURFIO COUT serializer. It splits NUM_CH command words into BITS_PER_CLK-bit lanes per if_clk_x2 cycle, aligned to the external phase strobe, for external ODDR/OBUFDS primitives.
New relative to the single-channel block:
- valid/ready command handshake with one-entry holding register
- idle-word insertion
- per-channel training and per-channel polarity inversion
- phase-lock status and sticky phase-error detection

Parameters:
NUM_CH, 4, number of COUT channels
WORD_BITS, 32, bits per command word
BITS_PER_CLK, 2, bits emitted per clock per channel (ODDR width)
TRAIN_VALUE, 32'hA55A6996, training word (WORD_BITS wide)
INV_MASK, {NUM_CH{1'b0}}, per-channel data inversion (full inversion incl. crossbar)
Derived: L = WORD_BITS/BITS_PER_CLK, the frame length in clocks. It must be a power of two and at least 4; elaboration error otherwise.

Ports:
if_clk_x2_i  in  1  serial-side clock
if_rst_n_i  in  1  asynchronous active-low reset
if_clk_x2_phase_i  in  1  one-cycle strobe marking frame clock 0
cmd_i  in  NUM_CH*WORD_BITS  command words, channel c at [c*WORD_BITS +: WORD_BITS]
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  holding register empty
train_i  in  NUM_CH  per-channel train select
sync_ok_o  out  1  phase counter locked
phase_err_o  out  1  sticky misaligned strobe
phase_err_clr_i  in  1  clears phase_err_o
dout_o  out  NUM_CH*BITS_PER_CLK  per-channel lane; bit 0 is first in time (ODDR D1)
frame_start_o  out  1  dout_o carries bits [BITS_PER_CLK-1:0] of a new word

Behaviour:
Reset (asynchronous, immediate):
- counter=0, phase_buf=0, sync_ok_o=0, phase_err_o=0
- holding register empty, so cmd_ready_o=1
- shift registers all 0, so dout_o = each channel's INV_MASK bit replicated
- frame_start_o=0
- A reset mid-word drops the word and any held command.

Phase tracking:
- phase_buf registers if_clk_x2_phase_i.
- When phase_buf=1, counter <= 2; otherwise counter <= counter+1 mod L.
- The first phase_buf=1 sets sync_ok_o (it stays set until reset).

Phase error:
- Raised when phase_buf=1 while sync_ok_o=1 and counter != 1. It is set on the next edge, and the counter is resynced as above.
- phase_err_clr_i clears it. A clear and a new error in the same cycle leave it set.

Load:
- do_capture is registered as (counter == L-3), so it is high during counter L-2.
- At the edge ending a do_capture cycle, if sync_ok_o=1, every channel loads its shift register. The source is chosen per channel:
  - train_i[c]=1: TRAIN_VALUE
  - else, holding full: held word c
  - else: idle word 0
- Any held entry is consumed at that load, even if every channel is training.
- Before sync_ok_o is set, no loads occur; shift registers stay 0.
- On all other cycles, each shift register shifts right by BITS_PER_CLK, zero-filled.

Output timing:
- dout_o[c] = shift[c][BITS_PER_CLK-1:0] XOR INV_MASK[c], registered.
- Bits [BITS_PER_CLK-1:0] appear during counter L-1. With one cycle of ODDR latency, they are on the wire at frame clock 0.
- frame_start_o is high during counter L-1 if a load occurred.

Handshake:
- cmd_ready_o = ~holding_full.
- Accept when cmd_valid_i and cmd_ready_o are both high.
- Accept and load cannot coincide with the register full. If an accept happens in the load cycle while the register is empty, the word waits for the next frame.
- cmd_ready_o rises the cycle after the consuming load.
- cmd_i is sampled only at accept.

Decomposition:
- Package turfio_pkg: TRAIN_VALUE default constant, and a function computing L with a power-of-two check.
- Sub-module turfio_cout_lane, instantiated NUM_CH times. It holds the shift register, load mux (train/held/idle) and inversion register.
- Phase counter, error logic and handshake stay in the top level.
- ODDRE1/OBUFDS instantiation stays outside this block.

Test Plan:
- Reset with INV_MASK=4'b0101 -> dout_o=8'b00110011, cmd_ready_o=1, sync_ok_o=0, phase_err_o=0.
- Strobe at cycle T, then accept ch0=0x12345678 -> sync_ok_o=1 at T+2; frame_start_o at counter 15. The ch0 lane then shows 00,10,11,01,... in successive cycles, and cmd_ready_o returns to 1 one cycle after the load.
- train_i=4'b0010 with a held command -> ch1 emits 10,01,01,10,... (0xA55A6996 LSB-first); ch0/2/3 emit the held words; the held entry is consumed.
- No cmd_valid_i for 3 frames -> all lanes emit 00 (or the INV_MASK level); frame_start_o still pulses each frame; cmd_ready_o stays 1.
- Strobe 3 cycles early after lock -> phase_err_o=1 and the counter resyncs. Assert phase_err_clr_i together with another misaligned strobe -> phase_err_o stays 1; clear alone -> 0.
- Drop if_rst_n_i mid-word with a held command -> dout_o returns to the INV_MASK level immediately; after release, cmd_ready_o=1 and no word is emitted until the next strobe.
